orpsoc_emb_soc_top: RTL and testbench
=====================================

Name: orpsoc_emb_soc_top

Overview:
Self-contained embedded SoC top for simulation. It contains a Wishbone single-port RAM and NUM_CORES simple "boot-scan" bus masters, arbitrated onto that RAM. The RAM is preloaded by hierarchical backdoor writes at time 0. After reset, each master reads words sequentially from its boot address, accumulates a checksum, and halts on the OR1K sim-exit word. Status appears on optional outputs; only clock and reset need be connected.

Parameters:
NUM_CORES, 1, number of scan masters (1..4)
MEM_WORDS, 32768, RAM depth in 32-bit words (power of two)
BOOT_ADDR, 32'h00000100, byte start address of master 0
CORE_STRIDE, 32'h00001000, byte offset between successive masters' start addresses
HALT_WORD, 32'h15000001, terminating word (l.nop 1)

Ports:
wb_clk_i  in  1  system clock; all logic on the rising edge
wb_rst_i  in  1  asynchronous, active-high reset
done_o  out  NUM_CORES  per-master halted flag
err_o  out  NUM_CORES  per-master flag: end of memory reached without HALT_WORD
checksum_o  out  32*NUM_CORES  per-master running sum; master i uses bits [32i+31:32i]
count_o  out  32*NUM_CORES  per-master count of words summed

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Clock port is wb_clk_i; reset port is wb_rst_i.
- RAM hierarchy is fixed so backdoor loads work:
  - instance wb_bfm_memory0 contains submodule ram0;
  - ram0 holds reg [31:0] mem [0:MEM_WORDS-1];
  - mem[i] holds byte address 4*i.
- Reset never modifies mem contents.
- RAM slave is Wishbone classic, 32-bit:
  - word index = adr[log2(MEM_WORDS)+1:2]; upper address bits are ignored (aliasing).
  - ack is registered: ack <= cyc & stb & ~ack, so it asserts the cycle after the request and lasts 1 cycle.
  - Read data is valid with ack.
  - Writes honour sel byte lanes; masters never write, but the write port must work.
  - ack resets to 0.
- Master FSM states: IDLE, REQ, GAP, HALT.
  - Reset: state=IDLE, adr=BOOT_ADDR+i*CORE_STRIDE, checksum=0, count=0, done=0, err=0.
  - IDLE -> REQ on the first clock after reset release.
  - REQ: assert cyc=stb=1, we=0, sel=4'hF; hold adr until ack.
  - On ack, if dat==HALT_WORD: done=1, go to HALT; the halt word is not summed or counted.
  - On ack, otherwise: checksum += dat (mod 2^32), count += 1, adr += 4, go to GAP.
  - If the incremented adr equals MEM_WORDS*4 (end of memory): err=1, done=1, go to HALT.
  - GAP: cyc=0 for exactly 1 cycle, then REQ. Steady-state cost is 3 cycles per word.
  - HALT: bus idle; outputs frozen until reset.
- Arbiter: round-robin over masters requesting cyc.
  - A grant is held for a master's whole cycle (until its ack); rotation happens only when cyc drops.
  - Combinational grant, so no extra latency when uncontended.
  - With NUM_CORES=1, master 0 is always granted.
  - Non-granted masters wait in REQ with their address held.
- Simultaneous HALT_WORD fetched at the last word: halt wins; done=1, err=0.
- Reset asserted mid-transaction: cyc/stb/ack drop immediately; all state returns to reset values; RAM is unchanged. After release, the scan restarts from the boot address.
- Outputs are driven directly from registers.

Test Plan:
- Preload mem[64..67]=1,2,3,32'h15000001; release reset -> done_o=1 within 15 cycles; checksum_o=6; count_o=3; err_o=0.
- mem[64]=32'hFFFFFFFF, mem[65]=2, mem[66]=HALT_WORD -> checksum_o=32'h00000001 (wrap); count_o=2.
- MEM_WORDS=128 with no HALT_WORD in mem[64..127], all words =1 -> done_o=1, err_o=1, count_o=64, checksum_o=64.
- Assert wb_rst_i mid-scan (after count_o=2) for 3 cycles -> outputs go to 0 immediately; RAM unchanged; rescan gives the same final checksum.
- NUM_CORES=2: master 1 starts at 0x1100 (mem[1088..]); program both streams -> both done; masters alternate grants; no cycle has two acks; checksums independent.
- Bus protocol check: ack never asserted without cyc&stb; exactly 1 ack per request; cyc low for 1 cycle between accesses.

Source files
------------

// File: rtl/orpsoc_emb_soc_top_if.sv
// Wishbone classic 32-bit bus bundle shared by the scan masters, the arbiter
// and the RAM slave.
interface orpsoc_emb_soc_top_if;
   // Handshake: a master raises cyc/stb and holds adr/we/sel/dat_w stable until
   // the slave answers with ack, a one-cycle pulse the cycle after the request;
   // dat_r is valid in the ack cycle and the master must drop cyc right after.
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic [3:0]  sel;
   logic        we;
   logic        cyc;
   logic        stb;
   logic        ack;

   modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack);
   modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack);
endinterface

// File: rtl/orpsoc_emb_soc_top.sv
// Simulation SoC: NUM_CORES boot-scan masters round-robin arbitrated onto a
// backdoor-loadable Wishbone RAM (wb_bfm_memory0.ram0.mem).

module orpsoc_wb_ram #(
   parameter int MEM_WORDS = 32768,
   parameter int AW        = 15
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   din,
   output logic [31:0]   dout
);
   reg [31:0] mem [0:MEM_WORDS-1];

   // No reset here: contents must survive wb_rst_i and accept backdoor loads.
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) mem[addr][8*b +: 8] <= din[8*b +: 8];
      end
      dout <= mem[addr];
   end
endmodule

module orpsoc_wb_bfm_memory #(
   parameter int MEM_WORDS = 32768
) (
   input logic clk,
   input logic rst,
   orpsoc_emb_soc_top_if.slave wb
);
   localparam int AW = $clog2(MEM_WORDS);

   logic       ack_q;
   logic       req;
   logic [3:0] we_b;
   logic       unused_adr_bits;

   assign req             = wb.cyc & wb.stb & ~ack_q;
   assign we_b            = {4{req & wb.we}} & wb.sel;
   assign wb.ack          = ack_q;
   // Upper address bits alias onto the array; the low two select byte lanes via sel.
   assign unused_adr_bits = ^{wb.adr[31:AW+2], wb.adr[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ack_q <= 1'b0;
      else     ack_q <= req;
   end

   orpsoc_wb_ram #(.MEM_WORDS(MEM_WORDS), .AW(AW)) ram0 (
      .clk  (clk),
      .we   (we_b),
      .addr (wb.adr[AW+1:2]),
      .din  (wb.dat_w),
      .dout (wb.dat_r)
   );
endmodule

module orpsoc_scan_master #(
   parameter int          MEM_WORDS = 32768,
   parameter logic [31:0] START_ADR = 32'h00000100,
   parameter logic [31:0] HALT_WORD = 32'h15000001
) (
   input  logic        clk,
   input  logic        rst,
   orpsoc_emb_soc_top_if.master wb,
   output logic        done,
   output logic        err,
   output logic [31:0] checksum,
   output logic [31:0] count
);
   typedef enum logic [1:0] {IDLE, REQ, GAP, HALT} state_t;

   localparam logic [31:0] END_ADR = 32'(MEM_WORDS * 4);

   state_t      state, state_nxt;
   logic [31:0] adr_q;
   logic [31:0] adr_inc;
   logic        is_halt;
   logic        cyc_c;

   assign adr_inc  = adr_q + 32'd4;
   assign is_halt  = (wb.dat_r == HALT_WORD);
   assign wb.adr   = adr_q;
   assign wb.dat_w = 32'd0;
   assign wb.sel   = 4'hF;
   assign wb.we    = 1'b0;
   assign wb.cyc   = cyc_c;
   assign wb.stb   = cyc_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cyc_c     = 1'b0;
      case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            cyc_c = 1'b1;
            if (wb.ack) begin
               if (is_halt || adr_inc == END_ADR) state_nxt = HALT;
               else                               state_nxt = GAP;
            end
         end
         GAP:     state_nxt = REQ;
         HALT:    state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   // A halt word fetched from the last location wins over the end-of-memory error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adr_q    <= START_ADR;
         checksum <= 32'd0;
         count    <= 32'd0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else if (state == REQ && wb.ack) begin
         if (is_halt) begin
            done <= 1'b1;
         end else begin
            checksum <= checksum + wb.dat_r;
            count    <= count + 32'd1;
            adr_q    <= adr_inc;
            if (adr_inc == END_ADR) begin
               err  <= 1'b1;
               done <= 1'b1;
            end
         end
      end
   end
endmodule

module orpsoc_emb_soc_top #(
   parameter int          NUM_CORES   = 1,
   parameter int          MEM_WORDS   = 32768,
   parameter logic [31:0] BOOT_ADDR   = 32'h00000100,
   parameter logic [31:0] CORE_STRIDE = 32'h00001000,
   parameter logic [31:0] HALT_WORD   = 32'h15000001
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   output logic [NUM_CORES-1:0]   done_o,
   output logic [NUM_CORES-1:0]   err_o,
   output logic [32*NUM_CORES-1:0] checksum_o,
   output logic [32*NUM_CORES-1:0] count_o
);
   localparam int GW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   orpsoc_emb_soc_top_if m_bus [NUM_CORES] ();
   orpsoc_emb_soc_top_if s_bus ();

   logic [NUM_CORES-1:0] m_cyc, m_stb, m_we, m_ack;
   logic [31:0]          m_adr   [NUM_CORES];
   logic [31:0]          m_dat_w [NUM_CORES];
   logic [3:0]           m_sel   [NUM_CORES];

   logic        bus_cyc, bus_stb, bus_we, bus_ack;
   logic [3:0]  bus_sel;
   logic [31:0] bus_adr, bus_dat_w, bus_dat_r;

   logic [GW-1:0] gnt, gnt_q, idx;
   logic          busy_q, found;

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
      orpsoc_scan_master #(
         .MEM_WORDS (MEM_WORDS),
         .START_ADR (32'(BOOT_ADDR + 32'(g) * CORE_STRIDE)),
         .HALT_WORD (HALT_WORD)
      ) u_core (
         .clk      (wb_clk_i),
         .rst      (wb_rst_i),
         .wb       (m_bus[g]),
         .done     (done_o[g]),
         .err      (err_o[g]),
         .checksum (checksum_o[32*g +: 32]),
         .count    (count_o[32*g +: 32])
      );
      assign m_cyc[g]       = m_bus[g].cyc;
      assign m_stb[g]       = m_bus[g].stb;
      assign m_we[g]        = m_bus[g].we;
      assign m_adr[g]       = m_bus[g].adr;
      assign m_dat_w[g]     = m_bus[g].dat_w;
      assign m_sel[g]       = m_bus[g].sel;
      assign m_ack[g]       = bus_ack & (gnt == GW'(g));
      assign m_bus[g].ack   = m_ack[g];
      assign m_bus[g].dat_r = bus_dat_r;
   end

   // Owner keeps the grant while its cycle is open; otherwise search round-robin
   // starting after the last owner, so an idle bus grants with no added latency.
   always_comb begin
      gnt   = gnt_q;
      idx   = gnt_q;
      found = 1'b0;
      if (!(busy_q && m_cyc[gnt_q])) begin
         for (int k = 1; k <= NUM_CORES; k++) begin
            idx = GW'((int'(gnt_q) + k) % NUM_CORES);
            if (!found && m_cyc[idx]) begin
               gnt   = idx;
               found = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         gnt_q  <= GW'(NUM_CORES - 1);
         busy_q <= 1'b0;
      end else begin
         gnt_q  <= gnt;
         busy_q <= m_cyc[gnt] & ~bus_ack;
      end
   end

   assign bus_cyc   = m_cyc[gnt];
   assign bus_stb   = m_stb[gnt];
   assign bus_we    = m_we[gnt];
   assign bus_adr   = m_adr[gnt];
   assign bus_dat_w = m_dat_w[gnt];
   assign bus_sel   = m_sel[gnt];

   assign s_bus.cyc   = bus_cyc;
   assign s_bus.stb   = bus_stb;
   assign s_bus.we    = bus_we;
   assign s_bus.adr   = bus_adr;
   assign s_bus.dat_w = bus_dat_w;
   assign s_bus.sel   = bus_sel;
   assign bus_ack     = s_bus.ack;
   assign bus_dat_r   = s_bus.dat_r;

   orpsoc_wb_bfm_memory #(.MEM_WORDS(MEM_WORDS)) wb_bfm_memory0 (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .wb  (s_bus)
   );
endmodule

// File: tb/tb_orpsoc_emb_soc_top.sv
// Directed bench: single-core SoC with a 128-word RAM for scan/wrap/end/reset
// cases, and a two-core SoC for arbitration and independent checksums.
module tb_orpsoc_emb_soc_top;
   localparam logic [31:0] HALT = 32'h15000001;
   localparam int A_WORDS = 2048;
   localparam int B_WORDS = 128;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   always #5 clk = ~clk;

   logic [1:0]  done_a, err_a;
   logic [63:0] sum_a, cnt_a;
   logic [0:0]  done_b, err_b;
   logic [31:0] sum_b, cnt_b;

   orpsoc_emb_soc_top #(.NUM_CORES(2), .MEM_WORDS(A_WORDS)) dut_a (
      .wb_clk_i (clk), .wb_rst_i (rst_a),
      .done_o (done_a), .err_o (err_a), .checksum_o (sum_a), .count_o (cnt_a)
   );

   orpsoc_emb_soc_top #(.NUM_CORES(1), .MEM_WORDS(B_WORDS)) dut_b (
      .wb_clk_i (clk), .wb_rst_i (rst_b),
      .done_o (done_b), .err_o (err_b), .checksum_o (sum_b), .count_o (cnt_b)
   );

   orpsoc_emb_soc_top_if mon_if ();
   assign mon_if.cyc   = dut_b.bus_cyc;
   assign mon_if.stb   = dut_b.bus_stb;
   assign mon_if.ack   = dut_b.bus_ack;
   assign mon_if.we    = dut_b.bus_we;
   assign mon_if.sel   = dut_b.bus_sel;
   assign mon_if.adr   = dut_b.bus_adr;
   assign mon_if.dat_w = dut_b.bus_dat_w;
   assign mon_if.dat_r = dut_b.bus_dat_r;

   int n_pass = 0;
   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] stim_q[$];

   // Bus monitors sampled 2 time units after the rising edge.
   int b_viol = 0;
   int a_acks = 0, a_dual = 0, a_alt = 0, a_noreq = 0;
   logic b_p1 = 1'b0, b_p2 = 1'b0;
   logic a_have_last = 1'b0, a_last_who = 1'b0;

   always @(posedge clk) begin
      #2;
      if (rst_b) begin
         b_p1 = 1'b0;
         b_p2 = 1'b0;
      end else begin
         if (mon_if.ack && !(mon_if.cyc && mon_if.stb)) b_viol++;
         if (b_p1 && mon_if.ack) b_viol++;
         if (b_p1 && mon_if.cyc) b_viol++;
         if (b_p2 && !mon_if.cyc && !done_b[0]) b_viol++;
         b_p2 = b_p1;
         b_p1 = mon_if.ack;
      end
      if (!rst_a && dut_a.bus_ack) begin
         a_acks++;
         if (!(dut_a.bus_cyc && dut_a.bus_stb)) a_noreq++;
         if (dut_a.m_ack == 2'b11) a_dual++;
         if (a_have_last && done_a == 2'b00 && dut_a.m_ack[1] == a_last_who) a_alt++;
         a_have_last = 1'b1;
         a_last_who  = dut_a.m_ack[1];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Writes stim_q into RAM at word base and pushes the expected sum/count/err.
   task automatic load_stream(input int sel, input int base, input int mem_words);
      logic [31:0] s, c, e;
      s = 0; c = 0; e = 0;
      for (int i = 0; i < stim_q.size(); i++) begin
         if (sel == 0) dut_a.wb_bfm_memory0.ram0.mem[base+i] = stim_q[i];
         else          dut_b.wb_bfm_memory0.ram0.mem[base+i] = stim_q[i];
      end
      for (int i = 0; i < stim_q.size(); i++) begin
         if (stim_q[i] == HALT) break;
         s = s + stim_q[i];
         c = c + 1;
         if (base + i + 1 == mem_words) begin
            e = 1;
            break;
         end
      end
      exp_q.push_back(s);
      exp_q.push_back(c);
      exp_q.push_back(e);
   endtask

   task automatic score(input string tag, input logic [31:0] sum, input logic [31:0] cnt,
                        input logic [31:0] err);
      if (exp_q.size() < 3) begin
         check({tag, "_sb_underflow"}, 32'(exp_q.size()), 32'd3);
         return;
      end
      check({tag, "_sum"}, sum, exp_q.pop_front());
      check({tag, "_count"}, cnt, exp_q.pop_front());
      check({tag, "_err"}, err, exp_q.pop_front());
   endtask

   task automatic wait_done_b(input int budget, output int cycles);
      cycles = 0;
      while (done_b[0] !== 1'b1 && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic fill_b(input int n, input logic [31:0] v);
      stim_q.delete();
      for (int i = 0; i < n; i++) stim_q.push_back(v);
   endtask

   initial begin
      int cycles;
      logic [31:0] v;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_done", 32'(done_b), 32'd0);
      check("rst_err", 32'(err_b), 32'd0);
      check("rst_sum", sum_b, 32'd0);
      check("rst_count", cnt_b, 32'd0);

      // Basic scan: 1+2+3 then halt
      stim_q = '{32'd1, 32'd2, 32'd3, HALT};
      load_stream(1, 64, B_WORDS);
      rst_b = 1'b0;
      wait_done_b(40, cycles);
      check("t1_done", 32'(done_b), 32'd1);
      check("t1_latency_le15", 32'(cycles <= 15), 32'd1);
      score("t1", sum_b, cnt_b, 32'(err_b));

      // Checksum wrap
      @(negedge clk); rst_b = 1'b1;
      stim_q = '{32'hFFFFFFFF, 32'd2, HALT};
      load_stream(1, 64, B_WORDS);
      @(negedge clk); rst_b = 1'b0;
      wait_done_b(40, cycles);
      check("t2_done", 32'(done_b), 32'd1);
      score("t2", sum_b, cnt_b, 32'(err_b));

      // Run off the end of memory with no halt word
      @(negedge clk); rst_b = 1'b1;
      fill_b(64, 32'd1);
      load_stream(1, 64, B_WORDS);
      @(negedge clk); rst_b = 1'b0;
      wait_done_b(400, cycles);
      check("t3_done", 32'(done_b), 32'd1);
      score("t3", sum_b, cnt_b, 32'(err_b));

      // Halt word in the very last location
      @(negedge clk); rst_b = 1'b1;
      fill_b(63, 32'd1);
      stim_q.push_back(HALT);
      load_stream(1, 64, B_WORDS);
      @(negedge clk); rst_b = 1'b0;
      wait_done_b(400, cycles);
      check("t4_done", 32'(done_b), 32'd1);
      score("t4", sum_b, cnt_b, 32'(err_b));

      // Reset in the middle of a scan, then rescan
      @(negedge clk); rst_b = 1'b1;
      stim_q = '{32'd5, 32'd6, 32'd7, 32'd8, HALT};
      load_stream(1, 64, B_WORDS);
      @(negedge clk); rst_b = 1'b0;
      cycles = 0;
      while (cnt_b != 32'd2 && cycles < 50) begin
         @(negedge clk);
         cycles++;
      end
      check("t5_reached_count2", cnt_b, 32'd2);
      rst_b = 1'b1;
      #1;
      check("t5_rst_count", cnt_b, 32'd0);
      check("t5_rst_sum", sum_b, 32'd0);
      check("t5_rst_cyc", 32'(mon_if.cyc), 32'd0);
      check("t5_rst_ack", 32'(mon_if.ack), 32'd0);
      repeat (3) @(negedge clk);
      check("t5_ram_kept", dut_b.wb_bfm_memory0.ram0.mem[64], 32'd5);
      rst_b = 1'b0;
      wait_done_b(60, cycles);
      check("t5_done", 32'(done_b), 32'd1);
      score("t5", sum_b, cnt_b, 32'(err_b));

      // Two masters sharing the RAM
      stim_q.delete();
      for (int i = 0; i < 10; i++) begin
         v = $urandom();
         if (v == HALT) v = 32'd0;
         stim_q.push_back(v);
      end
      stim_q.push_back(HALT);
      load_stream(0, 64, A_WORDS);
      stim_q.delete();
      for (int i = 0; i < 7; i++) begin
         v = 32'($urandom_range(1, 32'h7FFFFFFF));
         stim_q.push_back(v);
      end
      stim_q.push_back(HALT);
      load_stream(0, 1088, A_WORDS);
      @(negedge clk); rst_a = 1'b0;
      cycles = 0;
      while (done_a !== 2'b11 && cycles < 300) begin
         @(negedge clk);
         cycles++;
      end
      check("a_done", 32'(done_a), 32'd3);
      score("a_core0", sum_a[31:0], cnt_a[31:0], 32'(err_a[0]));
      score("a_core1", sum_a[63:32], cnt_a[63:32], 32'(err_a[1]));
      check("a_total_acks", 32'(a_acks), 32'd19);
      check("a_dual_ack", 32'(a_dual), 32'd0);
      check("a_alternation", 32'(a_alt), 32'd0);
      check("a_ack_without_req", 32'(a_noreq), 32'd0);
      check("b_protocol", 32'(b_viol), 32'd0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
